// File: rtl/mult_div_unit_if.sv
// Bus bundle between the EX stage and the iterative multiply/divide unit.
// master: pipeline side (drives operands and strobes); slave: the unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, abort,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, abort,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// op: 00 mult, 01 multu, 10 div, 11 divu. Fixed latency: one radix-2 step per
// cycle for 32 cycles, one sign-fix cycle, one done cycle.
// Optional feature: define MDU_ABORT_EN to let abort flush an operation that is
// in CALC or FIX; without it the abort input is ignored.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    mult_div_unit_if.slave mdu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Two's-complement negate of a WIDTH-bit value when n is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        logic [WIDTH-1:0] r;
        if (n) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate of a double-width value when n is set.
    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
        logic [2*WIDTH-1:0] r;
        if (n) begin
            r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;        // |a| for multiply, |b| for divide
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d; // product / quotient must be negated
    logic               neg_rem_q, neg_rem_d; // remainder takes dividend sign
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_out_q, dbz_out_d;

    logic               abort_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_top_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;

`ifdef MDU_ABORT_EN
    assign abort_s = mdu.abort;
`else
    logic abort_unused_s;
    assign abort_unused_s = mdu.abort;
    assign abort_s        = 1'b0;
`endif

    // Operand conditioning: signed ops work on magnitudes.
    assign a_neg_s = ~mdu.op[0] & mdu.a[WIDTH-1];
    assign b_neg_s = ~mdu.op[0] & mdu.b[WIDTH-1];
    assign a_abs_s = neg_if(mdu.a, a_neg_s);
    assign b_abs_s = neg_if(mdu.b, b_neg_s);

    // Shift-add multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next_s = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
    // A zero divisor always "fits", giving an all-ones quotient and |a| remainder.
    assign div_top_s  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff_s = div_top_s - {1'b0, opb_q};
    assign div_next_s = div_diff_s[WIDTH] ? {div_top_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix_s = neg_if2(acc_q, neg_res_q);

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu.hi_we) begin
                    hi_d = mdu.wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (mdu.lo_we) begin
                    lo_d = mdu.wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (mdu.start) begin
                    is_div_d  = mdu.op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    dbz_d     = mdu.op[1] & (mdu.b == {WIDTH{1'b0}});
                    opb_d     = mdu.op[1] ? b_abs_s : a_abs_s;
                    acc_d     = {{WIDTH{1'b0}}, (mdu.op[1] ? a_abs_s : b_abs_s)};
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_CALC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (abort_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next_s : mul_next_s;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_FIX;
                    end else begin
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                        if (dbz_q) begin
                            lo_d = {WIDTH{1'b1}};
                        end else begin
                            lo_d = neg_if(acc_q[WIDTH-1:0], neg_res_q);
                        end
                    end else begin
                        hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix_s[WIDTH-1:0];
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        dbz_out_d = done_d & dbz_q;
    end

    // State, datapath and output registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            opb_q     <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dbz_out_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_by_zero
// and the expected done cycle; a negedge monitor pops and compares on done.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    mult_div_unit_if mdu();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mdu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mdu.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("hi", {32'd0, mdu.hi}, {32'd0, e.hi});
                chk("lo", {32'd0, mdu.lo}, {32'd0, e.lo});
                chk("div_by_zero", {63'd0, mdu.div_by_zero}, {63'd0, e.dbz});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (mdu.div_by_zero) begin
            chk("dbz_without_done", 64'd1, 64'd0);
        end
    end

    // Issue one op at a negedge; returns the edge count n before the start edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                            input logic hwe, input logic [31:0] wd, output int n);
        exp_t e;
        @(negedge clk);
        n          = cyc;
        mdu.op     = op;
        mdu.a      = a;
        mdu.b      = b;
        mdu.start  = 1'b1;
        mdu.hi_we  = hwe;
        mdu.wdata  = wd;
        e.hi  = ehi;
        e.lo  = elo;
        e.dbz = edbz;
        e.cyc = n + 34;
        sb.push_back(e);
        @(negedge clk);
        mdu.start  = 1'b0;
        mdu.hi_we  = 1'b0;
        chk("busy_after_start", {63'd0, mdu.busy}, 64'd1);
    endtask

    // Wait through the fixed latency and check busy drops on schedule.
    task automatic finish_op(input int n);
        while (cyc < n + 34) @(negedge clk);
        chk("busy_in_done", {63'd0, mdu.busy}, 64'd1);
        @(negedge clk);
        chk("busy_after_done", {63'd0, mdu.busy}, 64'd0);
        chk("result_seen", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        int n;
        start_op(op, a, b, ehi, elo, edbz, 1'b0, 32'd0, n);
        finish_op(n);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        mdu.start = 1'b0;
        mdu.op    = 2'b00;
        mdu.a     = 32'd0;
        mdu.b     = 32'd0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        mdu.wdata = 32'd0;
        mdu.abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, mdu.busy}, 64'd0);
        chk("rst_done", {63'd0, mdu.done}, 64'd0);
        chk("rst_dbz", {63'd0, mdu.div_by_zero}, 64'd0);
        chk("rst_hi", {32'd0, mdu.hi}, 64'd0);
        chk("rst_lo", {32'd0, mdu.lo}, 64'd0);

        // Directed multiply / divide vectors.
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_op(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
        run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
        run_op(2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0);
        run_op(2'b01, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0);
        run_op(2'b00, 32'h7FFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFE, 1'b0);

        // start while busy is ignored; first result intact.
        start_op(2'b01, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, n);
        while (cyc < n + 5) @(negedge clk);
        mdu.op = 2'b00; mdu.a = 32'd3; mdu.b = 32'd4; mdu.start = 1'b1;
        @(negedge clk);
        mdu.start = 1'b0;
        while (cyc < n + 20) @(negedge clk);
        mdu.op = 2'b11; mdu.a = 32'd9; mdu.b = 32'd0; mdu.start = 1'b1;
        @(negedge clk);
        mdu.start = 1'b0;
        finish_op(n);

        // mthi / mtlo in IDLE.
        @(negedge clk);
        mdu.hi_we = 1'b1; mdu.wdata = 32'h00001234;
        @(negedge clk);
        mdu.hi_we = 1'b0;
        chk("mthi_idle", {32'd0, mdu.hi}, 64'h1234);
        mdu.lo_we = 1'b1; mdu.wdata = 32'h0BADF00D;
        @(negedge clk);
        mdu.lo_we = 1'b0;
        chk("mtlo_idle", {32'd0, mdu.lo}, 64'h0BADF00D);
        chk("mtlo_keeps_hi", {32'd0, mdu.hi}, 64'h1234);

        // mthi together with start, then writes during CALC are ignored.
        start_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1, 32'hAAAA5555, n);
        chk("mthi_with_start", {32'd0, mdu.hi}, 64'hAAAA5555);
        while (cyc < n + 3) @(negedge clk);
        mdu.lo_we = 1'b1; mdu.hi_we = 1'b1; mdu.wdata = 32'h0000DEAD;
        @(negedge clk);
        mdu.lo_we = 1'b0; mdu.hi_we = 1'b0;
        chk("mtlo_busy_ignored", {32'd0, mdu.lo}, 64'h0BADF00D);
        chk("mthi_busy_ignored", {32'd0, mdu.hi}, 64'hAAAA5555);
        finish_op(n);

        // Asynchronous reset in the middle of a divide.
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        start_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 32'd0, n);
        while (cyc < n + 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", {63'd0, mdu.busy}, 64'd0);
        chk("midop_rst_hi", {32'd0, mdu.hi}, 64'd0);
        chk("midop_rst_lo", {32'd0, mdu.lo}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", 64'(sb.size()), 64'd0);
        chk("idle_after_rst", {63'd0, mdu.busy}, 64'd0);

        // Abort mid-CALC.
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        start_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 32'd0, n);
        while (cyc < n + 10) @(negedge clk);
        mdu.abort = 1'b1;
        @(negedge clk);
        mdu.abort = 1'b0;
`ifdef MDU_ABORT_EN
        sb.delete();
        chk("abort_busy", {63'd0, mdu.busy}, 64'd0);
        chk("abort_hi_kept", {32'd0, mdu.hi}, 64'd2);
        chk("abort_lo_kept", {32'd0, mdu.lo}, 64'd14);
        repeat (30) @(negedge clk);
        chk("abort_no_done", 64'(sb.size()), 64'd0);
`else
        chk("abort_ignored_busy", {63'd0, mdu.busy}, 64'd1);
        finish_op(n);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
